// File: rtl/sfixed_pkg.sv
// Shared types, constants and the Q7.8 saturation helper for the affine sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sfixed_pkg;

    localparam int IN_W    = 8;      // Q3.4 operand width
    localparam int FRAC_IN = 4;      // fraction bits of operands
    localparam int OUT_W   = 16;     // Q7.8 result width
    localparam int ACC_W   = 18;     // accumulator width, >= OUT_W+2
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef logic signed [IN_W-1:0]  sfix_q3_4_t;
    typedef logic signed [OUT_W-1:0] sfix_q7_8_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL0 = 2'd1,
        MUL1 = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        sfix_q7_8_t val;
        logic       sat;
    } sat_res_t;

    // Clamp an accumulator value into the Q7.8 range and flag clipping.
    function automatic sat_res_t sat16(input acc_t acc);
        sat_res_t r;
        if (acc > acc_t'(SAT_MAX)) begin
            r.val = sfix_q7_8_t'(SAT_MAX);
            r.sat = 1'b1;
        end else if (acc < acc_t'(SAT_MIN)) begin
            r.val = sfix_q7_8_t'(SAT_MIN);
            r.sat = 1'b1;
        end else begin
            r.val = acc[OUT_W-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sfixed_mult_9x9_x3.sv
// Two-lane signed fixed-point multiplier (lanes x/y); output slice selectable.
// Latency: combinational, result valid in the same cycle as the operands.
// Backpressure: none; the caller owns sequencing.
//
// Ports:
//   a_x_i, b_x_i : lane x operands (signed, A/B formats)
//   a_y_i, b_y_i : lane y operands
//   p_x_o, p_y_o : products sliced to 1+OUT_LEFT+OUT_RIGHT bits
module sfixed_mult_9x9_x3 #(
    parameter int A_INT     = 3,
    parameter int A_FRAC    = 4,
    parameter int B_INT     = 3,
    parameter int B_FRAC    = 4,
    parameter int OUT_LEFT  = 7,
    parameter int OUT_RIGHT = 8
) (
    input  logic signed [A_INT+A_FRAC:0]       a_x_i,
    input  logic signed [B_INT+B_FRAC:0]       b_x_i,
    input  logic signed [A_INT+A_FRAC:0]       a_y_i,
    input  logic signed [B_INT+B_FRAC:0]       b_y_i,
    output logic signed [OUT_LEFT+OUT_RIGHT:0] p_x_o,
    output logic signed [OUT_LEFT+OUT_RIGHT:0] p_y_o
);

    localparam int A_W = 1 + A_INT + A_FRAC;
    localparam int B_W = 1 + B_INT + B_FRAC;
    localparam int P_W = A_W + B_W;
    localparam int O_W = 1 + OUT_LEFT + OUT_RIGHT;
    // Position of the lowest kept bit in the full-precision product.
    localparam int LSB = A_FRAC + B_FRAC - OUT_RIGHT;

    logic signed [P_W-1:0] full_x;
    logic signed [P_W-1:0] full_y;

    // Widen both operands first so the signed product is computed at full width.
    assign full_x = P_W'(a_x_i) * P_W'(b_x_i);
    assign full_y = P_W'(a_y_i) * P_W'(b_y_i);

    assign p_x_o = full_x[LSB +: O_W];
    assign p_y_o = full_y[LSB +: O_W];

endmodule

// File: rtl/sfixed_affine2_seq.sv
// 2-D affine transform out = M*v + t on a shared two-lane multiplier, Q3.4 in, Q7.8 saturated out.
// Latency: accept edge E0 -> out_valid after E0+2; one request in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid / in_ready    : request handshake
//   m00..m11, vx, vy, tx, ty : Q3.4 operands, sampled on acceptance
//   out_valid / out_ready  : result handshake
//   out_x, out_y, out_sat  : Q7.8 result and saturation flag
module sfixed_affine2_seq
    import sfixed_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   m00,
    input  logic [IN_W-1:0]   m01,
    input  logic [IN_W-1:0]   m10,
    input  logic [IN_W-1:0]   m11,
    input  logic [IN_W-1:0]   vx,
    input  logic [IN_W-1:0]   vy,
    input  logic [IN_W-1:0]   tx,
    input  logic [IN_W-1:0]   ty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_x,
    output logic [OUT_W-1:0]  out_y,
    output logic              out_sat
);

    state_t     state_q, state_d;

    sfix_q3_4_t m00_q, m01_q, m10_q, m11_q;
    sfix_q3_4_t vx_q, vy_q, tx_q, ty_q;

    acc_t       acc_x_q, acc_x_d;
    acc_t       acc_y_q, acc_y_d;
    sfix_q7_8_t out_x_q, out_x_d;
    sfix_q7_8_t out_y_q, out_y_d;
    logic       out_sat_q, out_sat_d;

    sfix_q3_4_t mul_ax, mul_bx, mul_ay, mul_by;
    sfix_q7_8_t prod_x, prod_y;

    acc_t       sum_x, sum_y;
    sat_res_t   sat_x, sat_y;

    logic       accept;

    assign accept = in_valid & in_ready;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MUL0;
            MUL0:    state_d = MUL1;
            MUL1:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs and multiplier operand steering.
    // Lanes are parked at zero outside the two multiply states so the
    // array does not toggle while idle or waiting on the consumer.
    // ---------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_ax    = '0;
        mul_bx    = '0;
        mul_ay    = '0;
        mul_by    = '0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            MUL0: begin
                mul_ax = m00_q;
                mul_bx = vx_q;
                mul_ay = m10_q;
                mul_by = vx_q;
            end
            MUL1: begin
                mul_ax = m01_q;
                mul_bx = vy_q;
                mul_ay = m11_q;
                mul_by = vy_q;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    sfixed_mult_9x9_x3 #(
        .A_INT    (3),
        .A_FRAC   (4),
        .B_INT    (3),
        .B_FRAC   (4),
        .OUT_LEFT (7),
        .OUT_RIGHT(8)
    ) u_mult (
        .a_x_i(mul_ax),
        .b_x_i(mul_bx),
        .a_y_i(mul_ay),
        .b_y_i(mul_by),
        .p_x_o(prod_x),
        .p_y_o(prod_y)
    );

    // ---------------------------------------------------------------
    // Operand capture: only on acceptance, so later input changes are ignored.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m00_q <= '0;
            m01_q <= '0;
            m10_q <= '0;
            m11_q <= '0;
            vx_q  <= '0;
            vy_q  <= '0;
            tx_q  <= '0;
            ty_q  <= '0;
        end else if (accept) begin
            m00_q <= sfix_q3_4_t'(m00);
            m01_q <= sfix_q3_4_t'(m01);
            m10_q <= sfix_q3_4_t'(m10);
            m11_q <= sfix_q3_4_t'(m11);
            vx_q  <= sfix_q3_4_t'(vx);
            vy_q  <= sfix_q3_4_t'(vy);
            tx_q  <= sfix_q3_4_t'(tx);
            ty_q  <= sfix_q3_4_t'(ty);
        end
    end

    // ---------------------------------------------------------------
    // Accumulate and saturate.
    // MUL0 seeds the accumulator with the translation aligned to Q.8
    // (shift by FRAC_IN) plus the first product; MUL1 adds the second
    // product and clamps once. ACC_W leaves headroom so the sum itself
    // never wraps before the clamp.
    // ---------------------------------------------------------------
    always_comb begin
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_sat_d = out_sat_q;
        sum_x     = acc_x_q + acc_t'(prod_x);
        sum_y     = acc_y_q + acc_t'(prod_y);
        sat_x     = sat16(sum_x);
        sat_y     = sat16(sum_y);
        case (state_q)
            MUL0: begin
                acc_x_d = (acc_t'(tx_q) <<< FRAC_IN) + acc_t'(prod_x);
                acc_y_d = (acc_t'(ty_q) <<< FRAC_IN) + acc_t'(prod_y);
            end
            MUL1: begin
                acc_x_d   = sum_x;
                acc_y_d   = sum_y;
                out_x_d   = sat_x.val;
                out_y_d   = sat_y.val;
                out_sat_d = sat_x.sat | sat_y.sat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_sat_q <= 1'b0;
        end else begin
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_x   = out_x_q;
    assign out_y   = out_y_q;
    assign out_sat = out_sat_q;

endmodule

// File: tb/tb_sfixed_affine2_seq.sv
// Self-checking bench for sfixed_affine2_seq: vector table, scoreboard, corner sequences.
// Latency: checks accept->out_valid of 2 edges and back-to-back accept spacing.
// Backpressure: exercises out_ready stalls and mid-transaction reset.
module tb_sfixed_affine2_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  m00, m01, m10, m11, vx, vy, tx, ty;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x, out_y;
    logic        out_sat;

    sfixed_affine2_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .m00      (m00),
        .m01      (m01),
        .m10      (m10),
        .m11      (m11),
        .vx       (vx),
        .vy       (vy),
        .tx       (tx),
        .ty       (ty),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] m00, m01, m10, m11, vx, vy, tx, ty;
        int ex;
        int ey;
        int es;
    } vec_t;

    typedef struct {
        int ex;
        int ey;
        int es;
        int acc;
    } exp_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;
    bit   valid_seen = 1'b0;
    bit   ii_on = 1'b0;
    int   last_acc = -1;
    vec_t tbl[7];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int x, input int y, input int p, input int q,
                                input int ex, input int ey, input int es);
        vec_t v;
        v.m00 = 8'(a); v.m01 = 8'(b); v.m10 = 8'(c); v.m11 = 8'(d);
        v.vx = 8'(x);  v.vy = 8'(y);  v.tx = 8'(p);  v.ty = 8'(q);
        v.ex = ex; v.ey = ey; v.es = es;
        return v;
    endfunction

    // Reference: exact Q7.8 sum in integers, then clamp.
    function automatic vec_t model(input vec_t v);
        int sx, sy;
        sx = int'(v.m00) * int'(v.vx) + int'(v.m01) * int'(v.vy) + int'(v.tx) * 16;
        sy = int'(v.m10) * int'(v.vx) + int'(v.m11) * int'(v.vy) + int'(v.ty) * 16;
        v.es = 0;
        if (sx > 32767)       begin v.ex = 32767;  v.es = 1; end
        else if (sx < -32768) begin v.ex = -32768; v.es = 1; end
        else                         v.ex = sx;
        if (sy > 32767)       begin v.ey = 32767;  v.es = 1; end
        else if (sy < -32768) begin v.ey = -32768; v.es = 1; end
        else                         v.ey = sy;
        return v;
    endfunction

    // Scoreboard: push on acceptance, pop on output handshake.
    always @(negedge clk) begin
        exp_t e;
        exp_t h;
        if (!rst) begin
            if (in_valid && in_ready) begin
                e = cur;
                e.acc = cyc + 1;
                // Busy window is MUL0, MUL1, DONE, so accepts are 4 edges apart.
                if (ii_on && last_acc >= 0) chk("accept_interval", e.acc - last_acc, 4);
                last_acc = e.acc;
                sb.push_back(e);
            end
            if (sb.size() == 0) begin
                chk("no_stale_out_valid", int'(out_valid), 0);
            end else if (out_valid) begin
                if (!valid_seen) begin
                    chk("latency", cyc - sb[0].acc, 2);
                    valid_seen = 1'b1;
                end
                if (out_ready) begin
                    h = sb.pop_front();
                    chk("out_x", int'($signed(out_x)), h.ex);
                    chk("out_y", int'($signed(out_y)), h.ey);
                    chk("out_sat", int'(out_sat), h.es);
                    valid_seen = 1'b0;
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        m00 = v.m00; m01 = v.m01; m10 = v.m10; m11 = v.m11;
        vx = v.vx;   vy = v.vy;   tx = v.tx;   ty = v.ty;
        cur.ex = v.ex; cur.ey = v.ey; cur.es = v.es; cur.acc = 0;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (in_ready && !rst) got = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("accept_within_budget", int'(got), 1);
        in_valid = 1'b0;
        // Scramble operands: captured values must be unaffected.
        m00 = 8'($urandom); m01 = 8'($urandom); m10 = 8'($urandom); m11 = 8'($urandom);
        vx  = 8'($urandom); vy  = 8'($urandom); tx  = 8'($urandom); ty  = 8'($urandom);
    endtask

    task automatic send(input vec_t v);
        drive(v);
        wait_accept();
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() > 0; k++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rel;
        vec_t v;

        tbl[0] = mk(16, 0, 0, 16, 32, -48, 0, 0, 512, -768, 0);
        tbl[1] = mk(16, 8, -16, 16, 16, 16, 16, -8, 640, -128, 0);
        tbl[2] = mk(-128, -128, -128, -128, -128, -128, 127, 127, 32767, 32767, 1);
        tbl[3] = mk(127, 127, 127, 127, -128, -128, -128, -128, -32768, -32768, 1);
        tbl[4] = mk(-128, 0, 0, -128, -128, -128, 0, 0, 16384, 16384, 0);
        tbl[5] = mk(-128, -128, -128, -128, -128, -128, -1, 0, 32752, 32767, 1);
        tbl[6] = mk(-8, 3, 5, -20, 20, -7, -3, 9, -229, 384, 0);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        {m00, m01, m10, m11, vx, vy, tx, ty} = '0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            send(tbl[i]);
            drain();
        end

        // Backpressure: hold result for 5 cycles, new request must wait.
        out_ready = 1'b0;
        send(tbl[1]);
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        chk("bp_out_valid", int'(out_valid), 1);
        drive(tbl[0]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_x", int'($signed(out_x)), 640);
            chk("bp_hold_y", int'($signed(out_y)), -128);
            chk("bp_hold_sat", int'(out_sat), 0);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid_held", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rel = cyc;
        wait_accept();
        chk("bp_accept_after_release", last_acc - rel, 2);
        drain();

        // Reset during MUL1: transaction is dropped, outputs clear at once.
        send(tbl[0]);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_x", int'(out_x), 0);
        chk("midrst_out_y", int'(out_y), 0);
        chk("midrst_out_sat", int'(out_sat), 0);
        sb.delete();
        valid_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        send(tbl[0]);
        drain();

        // Back-to-back random requests.
        ii_on = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 10; i++) begin
            v = mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0);
            v = model(v);
            send(v);
        end
        drain();
        ii_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
